// File: rtl/bitonic_batch_loader_if.sv
// Handshake and batch bus between the record source, the batch loader and
// the bitonic sorting network downstream.
interface bitonic_batch_loader_if #(
  parameter int NUM = 4,
  parameter int W   = 16
);
  localparam int CW = $clog2(NUM + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_data;
  logic                 direction;
  logic                 flush;
  logic                 batch_valid;
  logic                 batch_ready;
  logic [NUM*W-1:0]     batch_data;
  logic [CW-1:0]        batch_count;
  logic                 batch_direction;

  modport master (
    output in_valid, in_data, direction, flush, batch_ready,
    input  in_ready, batch_valid, batch_data, batch_count, batch_direction
  );

  modport slave (
    input  in_valid, in_data, direction, flush, batch_ready,
    output in_ready, batch_valid, batch_data, batch_count, batch_direction
  );
endinterface

// File: rtl/bitonic_batch_loader.sv
// Gathers serial records into a NUM-wide batch held stable for the bitonic
// network; partial batches closed by flush are padded to sort to the tail.
module bitonic_batch_loader #(
  parameter int NUM = 4,
  parameter int W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  bitonic_batch_loader_if.slave  bus
);
  localparam int CW = $clog2(NUM + 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    post;
  logic             xfer;
  logic             close;
  logic             dir_eff;
  logic [W-1:0]     pad;
  logic [NUM*W-1:0] data_q;
  logic [CW-1:0]    count_q;
  logic             dir_q;

  always_comb begin
    xfer    = (state == FILL) && bus.in_valid;
    post    = cnt + CW'(xfer);
    close   = (state == FILL) && ((post == CW'(NUM)) || (bus.flush && (post != '0)));
    // A flush together with the first record must pad using that record's direction.
    dir_eff = (xfer && (cnt == '0)) ? bus.direction : dir_q;
    pad     = {W{dir_eff}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      cnt     <= '0;
      data_q  <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
    end else if (state == FILL) begin
      if (xfer) begin
        cnt <= post;
        if (cnt == '0) dir_q <= bus.direction;
      end
      for (int unsigned i = 0; i < NUM; i++) begin
        if (xfer && (CW'(i) == cnt))
          data_q[i*W +: W] <= bus.in_data;
        else if (close && (CW'(i) >= post))
          data_q[i*W +: W] <= pad;
      end
      if (close) begin
        state   <= HOLD;
        count_q <= post;
      end
    end else if (bus.batch_ready) begin
      state <= FILL;
      cnt   <= '0;
    end
  end

  assign bus.in_ready        = (state == FILL);
  assign bus.batch_valid     = (state == HOLD);
  assign bus.batch_data      = data_q;
  assign bus.batch_count     = count_q;
  assign bus.batch_direction = dir_q;
endmodule

// File: tb/tb_bitonic_batch_loader.sv
// Directed bench for bitonic_batch_loader with NUM=4, W=16.
module tb_bitonic_batch_loader;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  bitonic_batch_loader_if #(.NUM(4), .W(16)) bus ();

  bitonic_batch_loader #(.NUM(4), .W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic dir);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.direction = dir;
    step();
    bus.in_valid  = 1'b0;
  endtask

  task automatic release_batch();
    bus.batch_ready = 1'b1;
    step();
    bus.batch_ready = 1'b0;
  endtask

  // Reference ascending sort of the four slots (what the network would output).
  function automatic logic [63:0] sort_asc(input logic [63:0] v);
    logic [15:0] s [4];
    logic [15:0] t;
    logic [63:0] r;
    for (int i = 0; i < 4; i++) s[i] = v[i*16 +: 16];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = s[i];
    return r;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    bus.in_valid    = 1'b1;
    bus.in_data     = 16'hDEAD;
    bus.direction   = 1'b1;
    bus.flush       = 1'b0;
    bus.batch_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_valid", 64'(bus.batch_valid), 64'd0);
    chk("rst_data", bus.batch_data, 64'h0);
    chk("rst_count", 64'(bus.batch_count), 64'd0);
    chk("rst_dir", 64'(bus.batch_direction), 64'd0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    step();

    // Full batch, ascending
    send(16'h0030, 1'b1);
    send(16'h0010, 1'b1);
    send(16'h0040, 1'b1);
    chk("full_not_yet", 64'(bus.batch_valid), 64'd0);
    send(16'h0020, 1'b1);
    chk("full_valid", 64'(bus.batch_valid), 64'd1);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_data", bus.batch_data, 64'h0020_0040_0010_0030);
    chk("full_count", 64'(bus.batch_count), 64'd4);
    chk("full_dir", 64'(bus.batch_direction), 64'd1);
    chk("full_net_out", sort_asc(bus.batch_data), 64'h0040_0030_0020_0010);
    release_batch();
    chk("full_release", 64'(bus.batch_valid), 64'd0);

    // Partial flush, descending; flush with the second record
    send(16'h0005, 1'b0);
    bus.flush = 1'b1;
    send(16'h0009, 1'b0);
    bus.flush = 1'b0;
    chk("part_valid", 64'(bus.batch_valid), 64'd1);
    chk("part_data", bus.batch_data, 64'h0000_0000_0009_0005);
    chk("part_count", 64'(bus.batch_count), 64'd2);
    chk("part_dir", 64'(bus.batch_direction), 64'd0);
    release_batch();

    // Back-pressure
    send(16'h0001, 1'b1);
    send(16'h0002, 1'b1);
    send(16'h0003, 1'b1);
    send(16'h0004, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0077;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_data", bus.batch_data, 64'h0004_0003_0002_0001);
    end
    bus.batch_ready = 1'b1;
    step();
    bus.batch_ready = 1'b0;
    chk("bp_released", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_slot0", bus.batch_data, 64'h0004_0003_0002_0077);
    chk("bp_fill_valid", 64'(bus.batch_valid), 64'd0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("bp_flush_data", bus.batch_data, 64'hFFFF_FFFF_FFFF_0077);
    chk("bp_flush_count", 64'(bus.batch_count), 64'd1);
    release_batch();

    // Direction latched from the first record only
    send(16'h0100, 1'b1);
    send(16'h0200, 1'b0);
    send(16'h0300, 1'b0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("dir_latch", 64'(bus.batch_direction), 64'd1);
    chk("dir_pad_data", bus.batch_data, 64'hFFFF_0300_0200_0100);
    chk("dir_count", 64'(bus.batch_count), 64'd3);
    release_batch();

    // Idle flush, then flush during HOLD
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("idle_flush_valid", 64'(bus.batch_valid), 64'd0);
    send(16'h000A, 1'b0);
    send(16'h000B, 1'b0);
    send(16'h000C, 1'b0);
    send(16'h000D, 1'b0);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hBEEF;
    step();
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("hold_flush_valid", 64'(bus.batch_valid), 64'd1);
    chk("hold_flush_data", bus.batch_data, 64'h000D_000C_000B_000A);
    chk("hold_flush_count", 64'(bus.batch_count), 64'd4);
    chk("hold_flush_dir", 64'(bus.batch_direction), 64'd0);
    release_batch();

    // Reset mid-batch, asynchronous
    send(16'h0011, 1'b1);
    send(16'h0022, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.batch_valid), 64'd0);
    chk("arst_data", bus.batch_data, 64'h0);
    chk("arst_count", 64'(bus.batch_count), 64'd0);
    chk("arst_dir", 64'(bus.batch_direction), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    rst = 1'b0;
    send(16'h00A1, 1'b1);
    send(16'h00A2, 1'b1);
    send(16'h00A3, 1'b1);
    chk("post_rst_not_yet", 64'(bus.batch_valid), 64'd0);
    send(16'h00A4, 1'b1);
    chk("post_rst_valid", 64'(bus.batch_valid), 64'd1);
    chk("post_rst_data", bus.batch_data, 64'h00A4_00A3_00A2_00A1);
    chk("post_rst_count", 64'(bus.batch_count), 64'd4);
    bus.batch_ready = 1'b1;
    step();
    bus.batch_ready = 1'b0;
    chk("post_rst_release", 64'(bus.batch_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bitonic_batch_loader.md
# bitonic_batch_loader

Collects serially arriving W-bit records into one NUM-record parallel batch for the bitonic sorting network, which sits directly downstream. The network is purely combinational, so this block holds the batch stable for as long as the consumer needs it. It also latches the sort direction once per batch. Partial batches are closed by `flush`, and unused slots are padded with a value that sorts to the tail of the network output.

## Interface
- `NUM`, 4: records per batch. Must be a power of two, ≥4, and equal to the network's `NUM`.
- `W`, 16: record width in bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_data` holds a record.
- `in_ready`  out  1  loader can accept a record.
- `in_data`  in  W  incoming record.
- `direction`  in  1  sort direction for the batch: 1 = ascending, 0 = descending. Sampled with the first record of each batch.
- `flush`  in  1  close the current partial batch.
- `batch_valid`  out  1  `batch_data` holds a complete batch.
- `batch_ready`  in  1  consumer takes the batch.
- `batch_data`  out  NUM*W  record i occupies `[W*i+W-1 : W*i]`. Drives the network's `IN`.
- `batch_count`  out  $clog2(NUM+1)  number of real, non-pad records in the batch (1..NUM).
- `batch_direction`  out  1  latched direction. Drives the network's `direction`.

## Operation
- Two states:
  - FILL: `in_ready`=1, `batch_valid`=0.
  - HOLD: `in_ready`=0, `batch_valid`=1.
- Input transfer: `in_valid && in_ready` in FILL.
  - The record is written to slot `cnt`, then `cnt` increments.
  - Arrival order maps to ascending slot index; the first record goes to slot 0.
- Direction capture: a transfer with `cnt`==0 latches `direction` into `batch_direction`. `direction` is ignored at all other times.
- FILL→HOLD occurs when:
  - a transfer brings `cnt` to NUM, or
  - `flush`=1 and the post-transfer count is ≥1. A transfer and `flush` in the same cycle include that record in the batch before closing.
- Flush rules:
  - `flush` with count 0 and no transfer is ignored.
  - `flush` in HOLD is ignored.
- On entering HOLD:
  - `batch_count` is set to the record count.
  - Slots with index ≥ count are written with the pad value: all-ones when `batch_direction`=1, all-zeros when 0. This places pads at the highest output indices after sorting.
- HOLD→FILL on `batch_valid && batch_ready`. `cnt` clears to 0. `batch_data`, `batch_count` and `batch_direction` keep their last values until overwritten.
- In HOLD, `batch_data`, `batch_count` and `batch_direction` are stable. `in_valid` is not acknowledged and `in_data` is ignored.
- Counter `cnt` is $clog2(NUM+1) bits wide and never exceeds NUM. There is no wrap-around; reaching NUM always forces HOLD.

## Timing
- Reset, asynchronous and immediate:
  - state = FILL, `cnt`=0
  - `batch_valid`=0, `batch_data`=0, `batch_count`=0, `batch_direction`=0
  - `in_ready` reads 1 while `rst` is high, but no transfer is recorded while `rst`=1.
- Reset mid-batch or during HOLD discards all collected records. No batch is presented afterwards.
- `in_ready` and `batch_valid` are decoded from the registered state only. There are no combinational paths from `in_valid`, `batch_ready` or `flush` to any output.
- Latency:
  - `batch_valid` rises on the edge that accepts the NUM-th record, or on the edge that samples an effective `flush`.
  - Network output is valid combinationally in that same cycle.
- Throughput: a full batch takes NUM transfer cycles plus at least 1 HOLD cycle. `in_ready`=0 for every HOLD cycle. The back-to-back minimum is NUM+1 cycles per batch.
- The consumer may hold `batch_ready` high continuously; HOLD then lasts exactly 1 cycle.
- `in_valid` may drop between records. Gaps do not affect slot assignment.

## Test plan
- Full batch, ascending: NUM=4, W=16, `direction`=1, records 0x0030, 0x0010, 0x0040, 0x0020 on consecutive cycles.
  - `batch_valid` rises after the 4th edge, with `batch_data`=0x0020_0040_0010_0030, `batch_count`=4, `batch_direction`=1.
  - Network `OUT` = 0x0040_0030_0020_0010.
- Partial flush, descending: `direction`=0, records 0x0005 and 0x0009, with `flush` in the same cycle as the 2nd record.
  - `batch_data`=0x0000_0000_0009_0005, `batch_count`=2, `batch_direction`=0.
- Back-pressure: `batch_ready`=0 for 5 cycles after a full batch while `in_valid`=1 with 0x0077.
  - `in_ready`=0 and `batch_data` unchanged throughout.
  - After `batch_ready` pulses, 0x0077 is accepted into slot 0 on the next cycle.
- Direction latch: first record sent with `direction`=1, then `direction` toggles to 0 for records 2–4.
  - `batch_direction`=1.
  - A flush after 3 records pads slot 3 with 0xFFFF.
- Idle flush and flush in HOLD:
  - `flush` with `cnt`=0 leaves `batch_valid`=0.
  - `flush` during HOLD changes nothing.
- Reset mid-operation: assert `rst` after 2 records.
  - All outputs return to their reset values asynchronously.
  - A subsequent 4-record batch lands in slots 0–3 in arrival order with `batch_count`=4.
